// File: rtl/cbx_ccff_loader.sv
// cbx_ccff_loader: configuration-chain sequencer for cbx/cby tiles.
// Streams WORD_W-bit bitstream words LSB-first into a tile ccff chain.
//
// Ports:
//   prog_clk, prog_reset_n   clock, synchronous active-low reset
//   start, abort             begin / cancel a load
//   cfg_data/valid/ready     bitstream word handshake
//   ccff_head, ccff_tail     chain serial in / serial out
//   chain_clk_en             chain clock-gate enable (shifts next edge)
//   busy, done, bit_count    load status
// Optional build macro CCFF_READBACK_EN adds rb_data/rb_valid, which
// repack the old chain contents leaving on ccff_tail into words.

module cbx_ccff_loader #(
    parameter int CHAIN_LEN = 24,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 5
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_clk_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count
`ifdef CCFF_READBACK_EN
    ,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
`endif
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_nxt;
    logic [IDX_W-1:0]  word_idx;
    logic              last_bit;
    logic              last_idx;

    assign cfg_ready = (state == FETCH);
    assign busy      = (state != IDLE);
    assign shreg_nxt = shreg >> 1;
    assign last_bit  = (bit_count == CNT_LAST);
    assign last_idx  = (word_idx == IDX_LAST);

    // ccff_head/chain_clk_en are registered, so they are loaded on the
    // edge that enters (or stays in) SHIFT and default low elsewhere.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state        <= IDLE;
            shreg        <= '0;
            word_idx     <= '0;
            bit_count    <= '0;
            ccff_head    <= 1'b0;
            chain_clk_en <= 1'b0;
            done         <= 1'b0;
        end else begin
            done         <= 1'b0;
            chain_clk_en <= 1'b0;
            ccff_head    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bit_count <= '0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (cfg_valid) begin
                        shreg        <= cfg_data;
                        word_idx     <= '0;
                        ccff_head    <= cfg_data[0];
                        chain_clk_en <= 1'b1;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        shreg     <= shreg_nxt;
                        bit_count <= bit_count + CNT_W'(1);
                        word_idx  <= word_idx + IDX_W'(1);
                        // Last chain bit wins over a word boundary so a
                        // partial final word never requests a new fetch.
                        if (last_bit) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (last_idx) begin
                            state <= FETCH;
                        end else begin
                            ccff_head    <= shreg_nxt[0];
                            chain_clk_en <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] rb_acc;
    logic [WORD_W-1:0] rb_word;

    // ccff_tail is the bit the chain drops on this cycle's shift edge.
    assign rb_word = rb_acc | (WORD_W'(ccff_tail) << word_idx);

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            rb_acc   <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (state == IDLE) begin
                rb_acc <= '0;
            end else if (state == SHIFT && !abort) begin
                if (last_bit || last_idx) begin
                    rb_data  <= rb_word;
                    rb_valid <= 1'b1;
                    rb_acc   <= '0;
                end else begin
                    rb_acc <= rb_word;
                end
            end
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: doc/cbx_ccff_loader.md
Name: cbx_ccff_loader

Overview:
- Configuration-chain sequencer for connection-block (cbx/cby) tiles.
- Accepts a bitstream as WORD_W-bit words over a valid/ready handshake.
- Serializes the words LSB-first onto the tile's ccff_head and issues one chain-shift enable per bit, for exactly CHAIN_LEN bits, then reports done.
- Sits between the top-level bitstream source and one tile's (or tile row's) ccff chain. Its chain_clk_en output drives the clock gate on the chain's prog_clk.

Parameters:
- CHAIN_LEN, 24, total configuration bits in the chain (6 ipin muxes x 4 SRAM bits). Must be >= 1.
- WORD_W, 8, input word width. Must be >= 1.
- CNT_W, 5, bit-counter width. Must satisfy 2**CNT_W > CHAIN_LEN.

Ports:
- prog_clk  input  1  programming clock; all logic is on its rising edge.
- prog_reset_n  input  1  synchronous, active-low reset.
- start  input  1  single-cycle request to begin a load; sampled in IDLE only.
- abort  input  1  cancels the load in progress.
- cfg_data  input  WORD_W  bitstream word; bit 0 is shifted first.
- cfg_valid  input  1  cfg_data is valid.
- cfg_ready  output  1  controller accepts a word this cycle.
- ccff_head  output  1  serial data into the chain.
- ccff_tail  input  1  serial data out of the chain.
- chain_clk_en  output  1  enable for the gated chain clock; the chain shifts on the edge after a cycle in which this is high.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when CHAIN_LEN bits have been shifted.
- bit_count  output  CNT_W  number of bits shifted so far in the current load.

Behaviour:
- Interface (already decided): one clock, prog_clk; reset is synchronous and active-low on prog_reset_n.
- Reset (prog_reset_n=0 at a clock edge): state=IDLE. cfg_ready, chain_clk_en, ccff_head, busy and done all 0. bit_count=0, shift register=0.
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE:
  - start=1 -> FETCH; bit_count cleared to 0 on the same edge.
  - start while busy is ignored.
- FETCH:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready: load cfg_data into the shift register, set word bit index=0, go to SHIFT.
  - cfg_ready is registered-state driven and combinationally independent of cfg_valid.
- SHIFT:
  - Each cycle: ccff_head=shreg[0] and chain_clk_en=1.
  - On the edge: shreg>>=1, bit_count+=1, word index+=1.
  - When bit_count reaches CHAIN_LEN-1 on this cycle (this is the last bit) -> DONE.
  - Otherwise, when word index = WORD_W-1 -> FETCH.
  - Fetch stalls: chain_clk_en=0 in FETCH, so the chain holds its contents while waiting.
- DONE:
  - done=1 for exactly one cycle, chain_clk_en=0, then -> IDLE.
  - bit_count holds CHAIN_LEN until the next start.
- Partial final word: when CHAIN_LEN mod WORD_W != 0, the unused upper bits of the last word are discarded. No extra word is requested.
- Latency: the first chain_clk_en occurs 1 cycle after the accepting handshake. With cfg_valid held high, a full load takes CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) + 2 cycles from start to done.
- abort:
  - In FETCH or SHIFT: next state IDLE, no done pulse, chain_clk_en=0 from the next cycle, bit_count holds its value.
  - In IDLE or DONE: no effect; DONE still pulses.
  - abort has priority over a simultaneous handshake.
- Reset asserted mid-load: the same return to IDLE as abort, plus bit_count cleared. Chain contents are undefined and must be reloaded.
- Outputs are registered except cfg_ready and busy, which are decoded from state.
- ccff_tail is unused unless the optional feature is enabled.

Optional Feature:
- Macro: CCFF_READBACK_EN.
- When defined:
  - Extra ports: rb_data output WORD_W, rb_valid output 1.
  - On each SHIFT cycle, ccff_tail (the old chain content leaving the chain) is packed LSB-first into a word register.
  - rb_valid pulses for one cycle with rb_data on every WORD_W captured bits, and on the final partial word (upper bits zero).
  - rb_valid has no backpressure.
  - Both outputs reset to 0.
- When undefined: the rb ports do not exist and no capture logic is built.

Test Plan:
- Reset, then start with words 0xA5,0x3C,0xF0 and cfg_valid held -> 24 chain_clk_en pulses; ccff_head sequence = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 0,0,0,0,1,1,1,1; done pulses at cycle 29 after start; bit_count=24.
- cfg_valid deasserted for 5 cycles before the second word -> chain_clk_en stays 0 for those cycles; total enabled pulses still 24; output bit sequence unchanged.
- CHAIN_LEN=20, WORD_W=8 -> exactly 3 handshakes; only bits 0-3 of the third word are shifted; done follows the 20th shift.
- abort asserted after 10 shifts -> IDLE the next cycle, no done, busy=0, bit_count=10. A new start then completes a full 24-bit load.
- Reset (prog_reset_n=0) during SHIFT -> all outputs 0 on the next edge. start asserted while busy -> ignored; bit_count continues uninterrupted.
- CCFF_READBACK_EN with a 24-flop chain model preloaded with 0x123456 and a second load -> rb_valid pulses 3 times with rb_data = 0x56, 0x34, 0x12.
